// File: rtl/fb_scheduler_pkg.sv
// Shared filterbank constants and the biquad stage encoding used on the engine request bus.
package fb_scheduler_pkg;

   localparam int N_FILTERS          = 16;
   localparam int FB_MAX_OUTSTANDING = 8;

   typedef enum logic [1:0] {
      STAGE_MOD = 2'd0,
      STAGE_CAR = 2'd1,
      STAGE_ENV = 2'd2
   } stage_t;

endpackage

// File: rtl/fb_scheduler_credit_counter.sv
// Up/down credit counter: counts ops issued but not yet retired, never drops below zero.
module credit_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] count_o,
   output logic             at_max_o,
   output logic             is_zero_o
);

   localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             dec_eff_s;

   // next count; a decrement at zero is a stray retire and is dropped
   always_comb begin
      dec_eff_s = dec_i && (count_q != '0);
      count_d   = count_q;
      if (inc_i && !dec_eff_s) begin
         count_d = count_q + ONE_C;
      end else if (dec_eff_s && !inc_i) begin
         count_d = count_q - ONE_C;
      end else begin
         count_d = count_q;
      end
   end

   // count register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o   = count_q;
   assign at_max_o  = (count_q == MAX_C);
   assign is_zero_o = (count_q == '0);

endmodule

// File: rtl/fb_scheduler.sv
// Issues every (channel, stage) biquad op of one vocoder frame in dependency order,
// limits in-flight ops with credits and pulses done_out once every result has retired.
module fb_scheduler
   import fb_scheduler_pkg::*;
#(
   parameter int NUM_FILTERS     = N_FILTERS,
   parameter int MAX_OUTSTANDING = FB_MAX_OUTSTANDING
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic                           sample_valid_in,
   output logic                           eng_valid_out,
   input  logic                           eng_ready_in,
   output logic [$clog2(NUM_FILTERS)-1:0] eng_chan_out,
   output logic [1:0]                     eng_stage_out,
   input  logic                           eng_retire_in,
   output logic                           busy_out,
   output logic                           done_out,
   output logic                           overrun_out,
   output logic [7:0]                     overrun_count_out
);

   localparam int CHAN_W = $clog2(NUM_FILTERS);
   localparam int CRED_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CHAN_W-1:0] CHAN_LAST_C = CHAN_W'(NUM_FILTERS - 1);
   localparam logic [CHAN_W-1:0] CHAN_ONE_C  = CHAN_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE_MOD = 3'd1,
      ST_ISSUE_CAR = 3'd2,
      ST_WAIT_MOD  = 3'd3,
      ST_ISSUE_ENV = 3'd4,
      ST_DRAIN     = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [CHAN_W-1:0]   chan_q, chan_d;
   logic                overrun_q;
   logic [7:0]          ovr_cnt_q;
   logic [CRED_W-1:0]   credits_s;
   logic                at_max_s, is_zero_s;
   logic                issue_s, valid_s, xfer_s, last_chan_s, done_s, busy_s;
   stage_t              stage_s;

   credit_counter #(.WIDTH(CRED_W), .MAX(MAX_OUTSTANDING)) u_credits (
      .clk_i     (clk_in),
      .rst_n_i   (rst_n_in),
      .inc_i     (xfer_s),
      .dec_i     (eng_retire_in),
      .count_o   (credits_s),
      .at_max_o  (at_max_s),
      .is_zero_o (is_zero_s)
   );

   assign xfer_s      = valid_s && eng_ready_in;
   assign last_chan_s = (chan_q == CHAN_LAST_C);

   // state register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state: ENV issue waits for every MOD/CAR result so ENV never reads a stale band
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      state_d = sample_valid_in ? ST_ISSUE_MOD : ST_IDLE;
         ST_ISSUE_MOD: state_d = (xfer_s && last_chan_s) ? ST_ISSUE_CAR : ST_ISSUE_MOD;
         ST_ISSUE_CAR: state_d = (xfer_s && last_chan_s) ? ST_WAIT_MOD : ST_ISSUE_CAR;
         ST_WAIT_MOD:  state_d = is_zero_s ? ST_ISSUE_ENV : ST_WAIT_MOD;
         ST_ISSUE_ENV: state_d = (xfer_s && last_chan_s) ? ST_DRAIN : ST_ISSUE_ENV;
         ST_DRAIN:     state_d = is_zero_s ? ST_IDLE : ST_DRAIN;
         default:      state_d = ST_IDLE;
      endcase
   end

   // outputs decoded from registered state and registered credit count
   always_comb begin
      issue_s = 1'b0;
      stage_s = STAGE_MOD;
      done_s  = 1'b0;
      case (state_q)
         ST_ISSUE_MOD: begin issue_s = 1'b1; stage_s = STAGE_MOD; end
         ST_ISSUE_CAR: begin issue_s = 1'b1; stage_s = STAGE_CAR; end
         ST_ISSUE_ENV: begin issue_s = 1'b1; stage_s = STAGE_ENV; end
         ST_DRAIN:     done_s = is_zero_s;
         default:      issue_s = 1'b0;
      endcase
      valid_s = issue_s && !at_max_s;
      busy_s  = (state_q != ST_IDLE);
   end

   // channel advances only on a transfer, so it is held stable under back-pressure
   always_comb begin
      if (xfer_s) begin
         chan_d = last_chan_s ? '0 : chan_q + CHAN_ONE_C;
      end else begin
         chan_d = chan_q;
      end
   end

   // channel index register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         chan_q <= '0;
      end else begin
         chan_q <= chan_d;
      end
   end

   // overrun pulse and saturating dropped-sample count
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         overrun_q <= 1'b0;
         ovr_cnt_q <= 8'd0;
      end else begin
         overrun_q <= sample_valid_in && busy_s;
         if (sample_valid_in && busy_s && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
         end else begin
            ovr_cnt_q <= ovr_cnt_q;
         end
      end
   end

   assign eng_valid_out     = valid_s;
   assign eng_chan_out      = chan_q;
   assign eng_stage_out     = stage_s;
   assign busy_out          = busy_s;
   assign done_out          = done_s;
   assign overrun_out       = overrun_q;
   assign overrun_count_out = ovr_cnt_q;

endmodule

// File: tb/tb_fb_scheduler.sv
// Scoreboard bench for fb_scheduler: a cycle model predicts handshakes, a monitor checks op order.
module tb_fb_scheduler;
   import fb_scheduler_pkg::*;

   localparam int NF   = 16;
   localparam int MAXO = 8;
   localparam int LAT  = 4;
   localparam logic [8:0] DONE_ITEM = 9'h1FF;

   logic       clk_in = 1'b0;
   logic       rst_n_in, sample_valid_in, eng_ready_in, eng_retire_in;
   logic       eng_valid_out, busy_out, done_out, overrun_out;
   logic [3:0] eng_chan_out;
   logic [1:0] eng_stage_out;
   logic [7:0] overrun_count_out;

   fb_scheduler dut (
      .clk_in            (clk_in),
      .rst_n_in          (rst_n_in),
      .sample_valid_in   (sample_valid_in),
      .eng_valid_out     (eng_valid_out),
      .eng_ready_in      (eng_ready_in),
      .eng_chan_out      (eng_chan_out),
      .eng_stage_out     (eng_stage_out),
      .eng_retire_in     (eng_retire_in),
      .busy_out          (busy_out),
      .done_out          (done_out),
      .overrun_out       (overrun_out),
      .overrun_count_out (overrun_count_out)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // engine model controls
   bit rdy_rand = 1'b0;
   bit stall    = 1'b0;
   int cyc      = 0;
   int ret_q[$];

   // reference model state
   bit         in_frame = 1'b0;
   bit         env_ok   = 1'b0;
   int         n_m      = 0;
   int         out_m    = 0;
   int         ovr_cnt_m = 0;
   bit         ovr_exp  = 1'b0;
   logic [8:0] sb[$];

   // monitor counters
   int  xfer_cnt = 0, done_cnt = 0, ovr_pulses = 0;
   bit  hold_prev = 1'b0;
   logic [3:0] prev_chan;
   logic [1:0] prev_stage;

   // engine: in-order retires LAT cycles after each transfer, optional random ready
   initial begin : engine
      bit x;
      forever begin
         @(negedge clk_in);
         x = eng_valid_out && eng_ready_in && rst_n_in;
         @(posedge clk_in);
         #1;
         cyc++;
         if (x) ret_q.push_back(cyc + LAT);
         if (!stall && ret_q.size() > 0 && ret_q[0] <= cyc) begin
            eng_retire_in = 1'b1;
            void'(ret_q.pop_front());
         end else begin
            eng_retire_in = 1'b0;
         end
         eng_ready_in = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // reference model: predicts valid/busy/done/overrun each cycle, pushes expected ops
   always @(negedge clk_in) begin : refmodel
      bit issue, v_exp, d_exp, x, r, wait_done;
      if (!rst_n_in) begin
         in_frame = 1'b0; env_ok = 1'b0; n_m = 0; out_m = 0;
         ovr_cnt_m = 0; ovr_exp = 1'b0; sb.delete();
      end else begin
         issue = in_frame && ((n_m < 2*NF) || (env_ok && n_m < 3*NF));
         v_exp = issue && (out_m < MAXO);
         d_exp = in_frame && (n_m == 3*NF) && (out_m == 0);
         chk("eng_valid", 32'(eng_valid_out), 32'(v_exp));
         chk("busy", 32'(busy_out), 32'(in_frame));
         chk("done", 32'(done_out), 32'(d_exp));
         chk("overrun", 32'(overrun_out), 32'(ovr_exp));
         chk("overrun_count", 32'(overrun_count_out), 32'(ovr_cnt_m));
         wait_done = in_frame && (n_m == 2*NF) && !env_ok && (out_m == 0);
         x = v_exp && eng_ready_in;
         r = eng_retire_in && (out_m != 0);
         ovr_exp = sample_valid_in && in_frame;
         if (ovr_exp && ovr_cnt_m < 255) ovr_cnt_m++;
         if (x && !r) out_m++;
         else if (r && !x) out_m--;
         if (x) n_m++;
         if (wait_done) env_ok = 1'b1;
         if (d_exp) begin
            in_frame = 1'b0; n_m = 0; env_ok = 1'b0;
         end else if (sample_valid_in && !in_frame) begin
            in_frame = 1'b1;
            for (int s = 0; s < 3; s++)
               for (int c = 0; c < NF; c++)
                  sb.push_back({3'b000, 2'(s), 4'(c)});
            sb.push_back(DONE_ITEM);
         end
      end
   end

   task automatic sb_pop(input string name, input logic [8:0] got);
      if (sb.size() == 0) chk({name, "_unexpected"}, 32'(got), 32'h0);
      else chk(name, 32'(got), 32'(sb.pop_front()));
   endtask

   // monitor: pops the scoreboard on every transfer and done, checks handshake stability
   always @(negedge clk_in) begin : monitor
      if (!rst_n_in) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", 32'(eng_valid_out), 32'd1);
            chk("hold_chan", 32'(eng_chan_out), 32'(prev_chan));
            chk("hold_stage", 32'(eng_stage_out), 32'(prev_stage));
         end
         if (eng_valid_out && eng_ready_in) begin
            xfer_cnt++;
            sb_pop("op_order", {3'b000, eng_stage_out, eng_chan_out});
         end
         if (done_out) begin
            done_cnt++;
            sb_pop("done_item", DONE_ITEM);
         end
         if (overrun_out) ovr_pulses++;
         hold_prev  = eng_valid_out && !eng_ready_in;
         prev_chan  = eng_chan_out;
         prev_stage = eng_stage_out;
      end
   end

   task automatic pulse();
      @(posedge clk_in); #1 sample_valid_in = 1'b1;
      @(posedge clk_in); #1 sample_valid_in = 1'b0;
   endtask

   task automatic wait_frame_end(input int budget);
      int k = 0;
      while (in_frame && k < budget) begin
         @(negedge clk_in);
         k++;
      end
      chk("frame_end_timeout", 32'(in_frame), 32'd0);
      repeat (2) @(negedge clk_in);
   endtask

   task automatic wait_n(input int target, input int budget);
      int k = 0;
      while (n_m < target && k < budget) begin
         @(negedge clk_in);
         k++;
      end
      chk("wait_n_timeout", 32'(n_m >= target), 32'd1);
   endtask

   task automatic run_frame(input string name, input int budget);
      int x0, d0;
      x0 = xfer_cnt; d0 = done_cnt;
      pulse();
      wait_frame_end(budget);
      chk({name, "_xfers"}, 32'(xfer_cnt - x0), 32'd48);
      chk({name, "_dones"}, 32'(done_cnt - d0), 32'd1);
      chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
      chk({name, "_busy_low"}, 32'(busy_out), 32'd0);
   endtask

   initial begin : timeout
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int x0, d0, o0;
      rst_n_in = 1'b0; sample_valid_in = 1'b0; eng_ready_in = 1'b1; eng_retire_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_valid", 32'(eng_valid_out), 32'd0);
      chk("rst_busy", 32'(busy_out), 32'd0);
      chk("rst_done", 32'(done_out), 32'd0);
      chk("rst_chan", 32'(eng_chan_out), 32'd0);
      chk("rst_stage", 32'(eng_stage_out), 32'd0);
      chk("rst_ovr_cnt", 32'(overrun_count_out), 32'd0);
      rst_n_in = 1'b1;
      repeat (2) @(posedge clk_in);

      // 1: plain frame, ready always high
      run_frame("t1", 400);

      // 2: random ready back-pressure
      rdy_rand = 1'b1;
      run_frame("t2", 800);
      rdy_rand = 1'b0;

      // 3: retires stalled for 40 cycles, credits must cap issue at MAXO
      stall = 1'b1;
      x0 = xfer_cnt; d0 = done_cnt;
      pulse();
      repeat (20) @(negedge clk_in);
      chk("t3_capped_xfers", 32'(xfer_cnt - x0), 32'(MAXO));
      chk("t3_valid_low", 32'(eng_valid_out), 32'd0);
      repeat (20) @(negedge clk_in);
      stall = 1'b0;
      wait_frame_end(600);
      chk("t3_xfers", 32'(xfer_cnt - x0), 32'd48);
      chk("t3_dones", 32'(done_cnt - d0), 32'd1);

      // 4: retires delayed around the MOD/CAR -> ENV boundary
      x0 = xfer_cnt; d0 = done_cnt;
      pulse();
      wait_n(31, 300);
      stall = 1'b1;
      repeat (25) @(negedge clk_in);
      chk("t4_no_env_early", 32'(eng_valid_out), 32'd0);
      stall = 1'b0;
      wait_frame_end(600);
      chk("t4_xfers", 32'(xfer_cnt - x0), 32'd48);
      chk("t4_dones", 32'(done_cnt - d0), 32'd1);

      // 5: overruns during a frame, then saturation
      o0 = ovr_pulses; d0 = done_cnt;
      pulse();
      repeat (5) @(posedge clk_in);
      pulse();
      repeat (3) @(posedge clk_in);
      pulse();
      pulse();
      wait_frame_end(600);
      chk("t5_ovr_pulses", 32'(ovr_pulses - o0), 32'd3);
      chk("t5_ovr_count", 32'(overrun_count_out), 32'd3);
      chk("t5_done", 32'(done_cnt - d0), 32'd1);
      @(posedge clk_in); #1 sample_valid_in = 1'b1;
      repeat (300) @(posedge clk_in);
      #1 sample_valid_in = 1'b0;
      wait_frame_end(600);
      chk("t5_ovr_sat", 32'(overrun_count_out), 32'd255);

      // 6: async reset mid ISSUE_CAR
      d0 = done_cnt;
      pulse();
      wait_n(20, 300);
      @(posedge clk_in);
      #3 rst_n_in = 1'b0;
      #1;
      chk("t6_valid", 32'(eng_valid_out), 32'd0);
      chk("t6_busy", 32'(busy_out), 32'd0);
      chk("t6_done", 32'(done_out), 32'd0);
      chk("t6_chan", 32'(eng_chan_out), 32'd0);
      chk("t6_ovr_cnt", 32'(overrun_count_out), 32'd0);
      repeat (3) @(posedge clk_in);
      #2 rst_n_in = 1'b1;
      repeat (40) @(negedge clk_in);
      chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
      chk("t6_idle", 32'(busy_out), 32'd0);
      run_frame("t6_after", 400);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
